aes_cipher_core: RTL and testbench
==================================

Name: aes_cipher_core

Overview:
- Iterative AES-128 encryption datapath that sits directly downstream of the key schedule and consumes its round keys.
- Drives the 4-bit round-key select toward the key schedule and reads the returned 128-bit round key.
- Performs AddRoundKey plus rounds 1..10, one round per clock, and emits the ciphertext with a one-cycle Done pulse.
- Feeds the system's output/UART stage.

Parameters:
- KEY_LAT, 2, clocks from a KeySel change until Key reflects it. The key schedule registers Key on Clk, so the default is 2. Legal range 1..3.
- NR, 10, number of rounds. Fixed at 10 for AES-128; any other value is unsupported.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  request to encrypt Din; sampled only in IDLE.
- Din  in  128  plaintext; byte 0 = Din[127:120], column-major state order.
- KeyRy  in  1  key schedule ready (expanded key valid).
- Key  in  128  round key from key schedule; byte 0 = Key[127:120].
- KeySel  out  4  round-key select to key schedule; registered.
- Busy  out  1  high from Start acceptance until Done.
- Done  out  1  one-cycle pulse; Dout valid in the same cycle.
- Dout  out  128  ciphertext; holds until the next Done.

Behaviour:
- Reset (Rst=0, async): state=IDLE, KeySel=0, Busy=0, Done=0, Dout=0, state register=0, round counter=0.
- FSM states: IDLE, WAIT_KEY, PRIME, ROUND, FINISH.
- IDLE, Start=1 and KeyRy=1: capture Din into the state register, KeySel<=1 if KEY_LAT=1 else KeySel<=0, Busy<=1. Next state is PRIME, or ROUND if KEY_LAT=1.
- IDLE, Start=1 and KeyRy=0: capture Din, Busy<=1, go to WAIT_KEY.
- WAIT_KEY: hold until KeyRy=1, then behave as the IDLE accept edge without recapturing Din.
- PRIME: lasts KEY_LAT-1 cycles. KeySel increments by 1 per cycle so KeySel leads the round counter by KEY_LAT.
- ROUND, round counter r=0..NR, one clock each; the Key sampled on edge r corresponds to RK[r]:
  - r=0: state <= state ^ Key.
  - 1<=r<=NR-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ Key.
  - r=NR: state <= ShiftRows(SubBytes(state)) ^ Key, then go to FINISH.
- KeySel increments each ROUND cycle and saturates at NR. It never exceeds 4'd10.
- FINISH (one cycle): Done=1, Dout=state, Busy=0, KeySel<=0, then IDLE.
- Latency with KEY_LAT=2: Start sampled at edge e0, KeySel=0 after e0, round 0 at e2, round 10 at e12, Done high in the cycle after e12 (13 clocks from the accept edge).
- Start is ignored while Busy=1; no queueing.
- KeyRy falling while Busy (key schedule re-run): abort to IDLE, Busy<=0, no Done, Dout unchanged, KeySel<=0.
- Start in the FINISH cycle is ignored. A back-to-back request is accepted one cycle after Done.
- SubBytes: 16 parallel S-box instances.
- MixColumns: xtime-based GF(2^8), reduction polynomial 0x11b. Purely combinational within the round.
- Reset asserted mid-operation: immediate return to the reset values. Dout clears to 0.

Test Plan:
- Key schedule loaded with 2b7e151628aed2a6abf7158809cf4f3c, KeyRy=1, Din=3243f6a8885a308d313198a2e0370734 -> Dout=3925841d02dc09fbdc118597196a0b32, Done 13 clocks after the accept edge, single-cycle pulse.
- Same key, Din=6bc1bee22e409f96e93d7e117393172a -> Dout=3ad77bb40d7a3660a89ecaf32466ef97. KeySel sequence 0,1,...,10, then 0.
- Start asserted with KeyRy=0, KeyRy rises 20 clocks later -> Busy high throughout, Dout correct, Done 13 clocks after KeyRy rise.
- Start pulsed again at round 5 with a different Din -> ignored; first ciphertext unchanged, no second Done.
- KeyRy dropped at round 4 -> Busy=0 next cycle, no Done, Dout keeps the previous ciphertext.
- Rst=0 asynchronously at round 7 -> all outputs 0 without a clock edge. After release, a new encryption completes correctly.

Source files
------------

// File: rtl/aes_cipher_core_if.sv
// Request/round-key/result bundle between the AES cipher core, its key
// schedule and the downstream consumer.
interface aes_cipher_core_if;
  logic         Start;
  logic [127:0] Din;
  logic         KeyRy;
  logic [127:0] Key;
  logic [3:0]   KeySel;
  logic         Busy;
  logic         Done;
  logic [127:0] Dout;

  modport slave (
    input  Start, Din, KeyRy, Key,
    output KeySel, Busy, Done, Dout
  );

  modport master (
    output Start, Din, KeyRy, Key,
    input  KeySel, Busy, Done, Dout
  );
endinterface

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: AddRoundKey plus NR rounds, one round
// per clock, with round keys fetched from an external key schedule.
module aes_cipher_core #(
  parameter int KEY_LAT = 2,
  parameter int NR      = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  aes_cipher_core_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    PRIME    = 3'd2,
    ROUND    = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam logic [3:0] NR4        = 4'(NR);
  localparam logic [3:0] PRIME_LAST = 4'(KEY_LAT - 2);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table entry 0 sits in the top byte, so index from the complemented input.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_t       state_r, state_s;
  logic [127:0] data_r, data_s;
  logic [3:0]   round_r, round_s;
  logic [3:0]   keysel_r, keysel_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic [127:0] dout_r, dout_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;
  logic [3:0]   keysel_inc_s;

  assign sr_s         = sub_shift(data_r);
  assign mc_s         = mix_columns(sr_s);
  assign keysel_inc_s = (keysel_r >= NR4) ? NR4 : keysel_r + 4'd1;

  assign bus.KeySel = keysel_r;
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.Dout   = dout_r;

  // State, datapath and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r  <= IDLE;
      data_r   <= 128'd0;
      round_r  <= 4'd0;
      keysel_r <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dout_r   <= 128'd0;
    end else begin
      state_r  <= state_s;
      data_r   <= data_s;
      round_r  <= round_s;
      keysel_r <= keysel_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      dout_r   <= dout_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic go;
    go       = 1'b0;
    state_s  = state_r;
    data_s   = data_r;
    round_s  = round_r;
    keysel_s = keysel_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    dout_s   = dout_r;

    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          data_s = bus.Din;
          busy_s = 1'b1;
          if (bus.KeyRy) begin
            go = 1'b1;
          end else begin
            state_s = WAIT_KEY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_KEY: begin
        if (bus.KeyRy) begin
          go = 1'b1;
        end else begin
          state_s = WAIT_KEY;
        end
      end
      PRIME: begin
        if (!bus.KeyRy) begin
          state_s  = IDLE;
          busy_s   = 1'b0;
          keysel_s = 4'd0;
          round_s  = 4'd0;
        end else begin
          keysel_s = keysel_inc_s;
          if (keysel_r == PRIME_LAST) begin
            state_s = ROUND;
          end else begin
            state_s = PRIME;
          end
        end
      end
      ROUND: begin
        if (!bus.KeyRy) begin
          // Key schedule is being re-run: drop the block, keep the old result.
          state_s  = IDLE;
          busy_s   = 1'b0;
          keysel_s = 4'd0;
          round_s  = 4'd0;
        end else begin
          keysel_s = keysel_inc_s;
          if (round_r == 4'd0) begin
            data_s  = data_r ^ bus.Key;
            round_s = round_r + 4'd1;
          end else if (round_r == NR4) begin
            data_s  = sr_s ^ bus.Key;
            dout_s  = sr_s ^ bus.Key;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = FINISH;
          end else begin
            data_s  = mc_s ^ bus.Key;
            round_s = round_r + 4'd1;
          end
        end
      end
      FINISH: begin
        keysel_s = 4'd0;
        round_s  = 4'd0;
        state_s  = IDLE;
      end
      default: begin
        state_s  = IDLE;
        busy_s   = 1'b0;
        keysel_s = 4'd0;
        round_s  = 4'd0;
      end
    endcase

    // Shared accept path for IDLE and WAIT_KEY; Din was captured on the request.
    if (go) begin
      round_s = 4'd0;
      if (KEY_LAT == 1) begin
        keysel_s = 4'd1;
        state_s  = ROUND;
      end else begin
        keysel_s = 4'd0;
        state_s  = PRIME;
      end
    end else begin
      round_s = round_s;
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core with a registered key-schedule model
// holding the FIPS-197 round keys for 2b7e151628aed2a6abf7158809cf4f3c.
module tb_aes_cipher_core;

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         Clk;
  logic         Rst;
  logic [127:0] rk [0:10];
  logic [3:0]   ks_log [0:13];
  int           checks;
  int           errors;
  int           lat;
  logic         busy_drop;
  logic         flag;

  aes_cipher_core_if bus ();

  aes_cipher_core #(.KEY_LAT(2), .NR(10)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Key schedule model: Key is registered from KeySel.
  always @(posedge Clk) bus.Key <= rk[bus.KeySel];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [127:0] din);
    @(negedge Clk);
    bus.Din   = din;
    bus.Start = 1'b1;
    @(posedge Clk);
  endtask

  // Called just after the accept edge; k indexes the negedge after edge e_k.
  task automatic wait_done(output int l, input int pulse_at, input logic [127:0] pulse_din);
    l = -1;
    busy_drop = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      bus.Start = (k == pulse_at);
      if (k == pulse_at) bus.Din = pulse_din;
      if (k < 14) ks_log[k] = bus.KeySel;
      if (bus.Done === 1'b1) begin
        l = k;
        break;
      end
      if (bus.Busy !== 1'b1) busy_drop = 1'b1;
    end
    bus.Start = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input logic [127:0] ct);
    check({tag, "_lat"}, 128'(lat), 128'd12);
    check({tag, "_dout"}, bus.Dout, ct);
    check({tag, "_busy_run"}, {127'd0, busy_drop}, 128'd0);
    check({tag, "_busy_at_done"}, {127'd0, bus.Busy}, 128'd0);
    @(negedge Clk);
    check({tag, "_done_pulse"}, {127'd0, bus.Done}, 128'd0);
    check({tag, "_keysel_clr"}, {124'd0, bus.KeySel}, 128'd0);
  endtask

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    checks = 0;
    errors = 0;
    bus.Start = 1'b0;
    bus.Din   = 128'd0;
    bus.KeyRy = 1'b1;
    Rst = 1'b0;

    #12;
    check("rst_keysel", {124'd0, bus.KeySel}, 128'd0);
    check("rst_busy", {127'd0, bus.Busy}, 128'd0);
    check("rst_done", {127'd0, bus.Done}, 128'd0);
    check("rst_dout", bus.Dout, 128'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // FIPS-197 Appendix B vector.
    start_req(PT1);
    wait_done(lat, -1, 128'd0);
    finish_checks("v1", CT1);

    // Second vector with the KeySel trace: 0..10, held at 10, then 0.
    start_req(PT2);
    wait_done(lat, -1, 128'd0);
    flag = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (ks_log[k] !== ((k > 10) ? 4'd10 : 4'(k))) flag = 1'b1;
    end
    check("v2_keysel_seq", {127'd0, flag}, 128'd0);
    finish_checks("v2", CT2);

    // Request while the key schedule is not ready.
    bus.KeyRy = 1'b0;
    start_req(PT2);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) flag = 1'b1;
    end
    check("wait_busy", {127'd0, flag}, 128'd0);
    bus.KeyRy = 1'b1;
    @(posedge Clk);
    wait_done(lat, -1, 128'd0);
    finish_checks("wait", CT2);

    // Start pulsed during round 5 with other data must be ignored.
    start_req(PT1);
    wait_done(lat, 6, PT2);
    finish_checks("ign", CT1);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0) flag = 1'b1;
    end
    check("ign_no_second_done", {127'd0, flag}, 128'd0);

    // KeyRy drops in round 4: abort, previous ciphertext kept.
    start_req(PT2);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    bus.KeyRy = 1'b0;
    @(negedge Clk);
    check("abort_busy", {127'd0, bus.Busy}, 128'd0);
    check("abort_keysel", {124'd0, bus.KeySel}, 128'd0);
    flag = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.Done !== 1'b0) flag = 1'b1;
      @(negedge Clk);
    end
    check("abort_no_done", {127'd0, flag}, 128'd0);
    check("abort_dout", bus.Dout, CT1);
    bus.KeyRy = 1'b1;

    // Asynchronous reset in round 7, then a clean encryption.
    start_req(PT1);
    for (int k = 0; k < 9; k++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    #2 Rst = 1'b0;
    #1;
    check("arst_keysel", {124'd0, bus.KeySel}, 128'd0);
    check("arst_busy", {127'd0, bus.Busy}, 128'd0);
    check("arst_done", {127'd0, bus.Done}, 128'd0);
    check("arst_dout", bus.Dout, 128'd0);
    @(negedge Clk);
    Rst = 1'b1;
    start_req(PT2);
    wait_done(lat, -1, 128'd0);
    finish_checks("post_rst", CT2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
